alsu_result_fifo: RTL and testbench

//   Downstream capture stage for the ALSU. Samples each valid ALSU result (out + leds)

---
 rtl/alsu_result_fifo.sv | 90 +++++++++
 tb/tb_alsu_result_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_result_fifo.sv
// ALSU result capture stage: packs each valid result into a 10-bit record
// and buffers it in a first-word-fall-through FIFO with drop/err counters.
module alsu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [5:0]               alsu_out,
  input  logic [15:0]              alsu_leds,
  input  logic [2:0]               op_tag,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [9:0]               m_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     ovf,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          err;
  logic          pop;
  logic          push;
  logic          drop;

  assign err     = |alsu_leds;
  assign m_valid = cnt != '0;
  assign full    = cnt == DEPTH_C;
  assign count   = cnt;
  // Output depends only on registered state, never on m_ready.
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  assign pop  = m_valid & m_ready;
  assign push = in_valid & (~full | pop) & ~flush;
  assign drop = in_valid & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= {err, op_tag, alsu_out};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= 1'b0;
      ovf_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (drop) begin
        ovf <= 1'b1;
        if (ovf_cnt != '1)
          ovf_cnt <= ovf_cnt + 1'b1;
      end
      if (push && err && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alsu_result_fifo.sv
// Randomized self-checking bench for alsu_result_fifo against a
// queue-based reference model of the capture FIFO.
module tb_alsu_result_fifo;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic [2:0]  op_tag;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [9:0]  m_data;
  logic [3:0]  count;
  logic        full;
  logic        ovf;
  logic [7:0]  ovf_cnt;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  logic [9:0] mq[$];
  logic       m_ovf;
  int         m_ovf_cnt;
  int         m_err_cnt;

  alsu_result_fifo #(.DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .op_tag(op_tag), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .ovf(ovf),
    .ovf_cnt(ovf_cnt), .err_cnt(err_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] exp_data();
    return (mq.size() > 0) ? mq[0] : 10'h000;
  endfunction

  // Advance the model on the current inputs, then cross one rising edge.
  task automatic tick();
    bit do_pop;
    bit is_full;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_ovf_cnt = 0;
      m_err_cnt = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && m_ready;
      is_full = mq.size() == 8;
      if (do_pop)
        void'(mq.pop_front());
      if (in_valid) begin
        if (!is_full || do_pop) begin
          mq.push_back({(alsu_leds != 0), op_tag, alsu_out});
          if (alsu_leds != 0 && m_err_cnt < 255)
            m_err_cnt++;
        end else begin
          m_ovf = 1;
          if (m_ovf_cnt < 255)
            m_ovf_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 0;
    alsu_out  = 0;
    alsu_leds = 0;
    op_tag    = 0;
    flush     = 0;
    m_ready   = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (m_valid !== 0 || m_data !== 0 || count !== 0 ||
          full !== 0 || ovf !== 0 || ovf_cnt !== 0 ||
          err_cnt !== 0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got v=%b d=%h c=%0d f=%b o=%b oc=%0d ec=%0d exp all 0",
                 i, m_valid, m_data, count, full, ovf, ovf_cnt, err_cnt);
      end
    end
  endtask

  task automatic test_single();
    in_valid  = 1;
    alsu_out  = 6'h2A;
    alsu_leds = 0;
    op_tag    = 3;
    tick();
    in_valid = 0;
    checks++;
    if (m_valid !== 1 || m_data !== 10'h0EA || count !== 1) begin
      errors++;
      $display("FAIL single_push got v=%b d=%h c=%0d exp v=1 d=0ea c=1",
               m_valid, m_data, count);
    end
    m_ready = 1;
    tick();
    m_ready = 0;
    checks++;
    if (m_valid !== 0 || m_data !== 0 || count !== 0) begin
      errors++;
      $display("FAIL single_pop got v=%b d=%h c=%0d exp v=0 d=0 c=0",
               m_valid, m_data, count);
    end
  endtask

  task automatic test_fill_drop();
    in_valid = 1;
    op_tag   = 1;
    for (int i = 0; i < 8; i++) begin
      alsu_out = 6'(i);
      tick();
    end
    checks++;
    if (full !== 1 || count !== 8 || ovf !== 0) begin
      errors++;
      $display("FAIL fill got full=%b c=%0d ovf=%b exp full=1 c=8 ovf=0",
               full, count, ovf);
    end
    alsu_out = 6'h3F;
    tick();
    in_valid = 0;
    checks++;
    if (ovf !== 1 || ovf_cnt !== 1 || count !== 8 || err_cnt !== 0) begin
      errors++;
      $display("FAIL drop got ovf=%b oc=%0d c=%0d ec=%0d exp 1 1 8 0",
               ovf, ovf_cnt, count, err_cnt);
    end
    m_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m_valid !== 1 || m_data !== {1'b0, 3'd1, 6'(i)}) begin
        errors++;
        $display("FAIL drain_order i=%0d got v=%b d=%h exp v=1 d=%h",
                 i, m_valid, m_data, {1'b0, 3'd1, 6'(i)});
      end
      tick();
    end
    m_ready = 0;
    checks++;
    if (count !== 0 || m_valid !== 0 || full !== 0) begin
      errors++;
      $display("FAIL drain_empty got c=%0d v=%b f=%b exp 0 0 0",
               count, m_valid, full);
    end
  endtask

  task automatic test_full_stream();
    in_valid = 1;
    op_tag   = 2;
    for (int i = 0; i < 8; i++) begin
      alsu_out = 6'(i);
      tick();
    end
    m_ready = 1;
    for (int k = 0; k < 20; k++) begin
      alsu_out = 6'(8 + k);
      checks++;
      if (m_data !== {1'b0, 3'd2, 6'(k)}) begin
        errors++;
        $display("FAIL stream_head k=%0d got %h exp %h",
                 k, m_data, {1'b0, 3'd2, 6'(k)});
      end
      tick();
      checks++;
      if (count !== 8 || full !== 1 || ovf_cnt !== 1) begin
        errors++;
        $display("FAIL stream_count k=%0d got c=%0d f=%b oc=%0d exp 8 1 1",
                 k, count, full, ovf_cnt);
      end
    end
    in_valid = 0;
    for (int k = 20; k < 28; k++) begin
      checks++;
      if (m_data !== {1'b0, 3'd2, 6'(k)}) begin
        errors++;
        $display("FAIL stream_tail k=%0d got %h exp %h",
                 k, m_data, {1'b0, 3'd2, 6'(k)});
      end
      tick();
    end
    m_ready = 0;
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL stream_empty got c=%0d exp 0", count);
    end
  endtask

  task automatic test_err_sat();
    in_valid  = 1;
    alsu_out  = 0;
    alsu_leds = 16'hFFFF;
    op_tag    = 6;
    tick();
    in_valid = 0;
    checks++;
    if (m_data !== 10'h380 || err_cnt !== 1) begin
      errors++;
      $display("FAIL err_rec got d=%h ec=%0d exp d=380 ec=1",
               m_data, err_cnt);
    end
    m_ready  = 1;
    in_valid = 1;
    for (int i = 0; i < 300; i++)
      tick();
    in_valid = 0;
    tick();
    m_ready   = 0;
    alsu_leds = 0;
    checks++;
    if (err_cnt !== 8'hFF || ovf_cnt !== 1 || count !== 0) begin
      errors++;
      $display("FAIL err_sat got ec=%h oc=%0d c=%0d exp ec=ff oc=1 c=0",
               err_cnt, ovf_cnt, count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      m_ready   = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      alsu_out  = 6'($urandom);
      alsu_leds = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      op_tag    = 3'($urandom);
      tick();
      checks++;
      if (m_valid !== (mq.size() > 0) || m_data !== exp_data() ||
          count !== 4'(mq.size()) || full !== (mq.size() == 8) ||
          ovf !== m_ovf || ovf_cnt !== 8'(m_ovf_cnt) ||
          err_cnt !== 8'(m_err_cnt)) begin
        errors++;
        $display("FAIL random i=%0d got v=%b d=%h c=%0d f=%b o=%b oc=%0d ec=%0d exp v=%b d=%h c=%0d f=%b o=%b oc=%0d ec=%0d",
                 i, m_valid, m_data, count, full, ovf, ovf_cnt, err_cnt,
                 mq.size() > 0, exp_data(), mq.size(), mq.size() == 8,
                 m_ovf, m_ovf_cnt, m_err_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush_rst();
    logic [7:0] oc_save;
    logic [7:0] ec_save;
    idle_inputs();
    flush = 1;
    tick();
    flush    = 0;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      alsu_out = 6'(i);
      tick();
    end
    checks++;
    if (count !== 5) begin
      errors++;
      $display("FAIL flush_fill got c=%0d exp 5", count);
    end
    oc_save   = 8'(m_ovf_cnt);
    ec_save   = 8'(m_err_cnt);
    flush     = 1;
    alsu_leds = 16'h0001;
    tick();
    flush     = 0;
    in_valid  = 0;
    alsu_leds = 0;
    checks++;
    if (count !== 0 || m_valid !== 0 || m_data !== 0 ||
        ovf_cnt !== oc_save || err_cnt !== ec_save) begin
      errors++;
      $display("FAIL flush got c=%0d v=%b d=%h oc=%0d ec=%0d exp 0 0 0 %0d %0d",
               count, m_valid, m_data, ovf_cnt, err_cnt, oc_save, ec_save);
    end
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alsu_out = 6'(10 + i);
      tick();
    end
    in_valid = 0;
    m_ready  = 1;
    tick();
    checks++;
    if (m_data !== {1'b0, 3'd0, 6'd11} || count !== 2) begin
      errors++;
      $display("FAIL mid_drain got d=%h c=%0d exp d=00b c=2",
               m_data, count);
    end
    rst      = 1;
    flush    = 1;
    in_valid = 1;
    tick();
    rst = 0;
    idle_inputs();
    checks++;
    if (m_valid !== 0 || m_data !== 0 || count !== 0 ||
        full !== 0 || ovf !== 0 || ovf_cnt !== 0 ||
        err_cnt !== 0) begin
      errors++;
      $display("FAIL rst_mid got v=%b d=%h c=%0d f=%b o=%b oc=%0d ec=%0d exp all 0",
               m_valid, m_data, count, full, ovf, ovf_cnt, err_cnt);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_ovf     = 0;
    m_ovf_cnt = 0;
    m_err_cnt = 0;
    test_reset();
    test_single();
    test_fill_drop();
    test_full_stream();
    test_err_sat();
    test_random();
    test_flush_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
